// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode table, field positions, and
// the decoded-entry record held by the stage's main and skid registers.
// No ports; imported by decode_fields, decode_stage_if users and decode_stage.
package decode_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // Instruction layout: opcode | RD / jump offset | RT | RS / immediate
  localparam int FIELD_W    = 8;
  localparam int OPCODE_LSB = 24;
  localparam int RD_LSB     = 16;
  localparam int RT_LSB     = 8;
  localparam int RS_LSB     = 0;

  // Packages cannot take parameters, so the record carries the widest
  // immediate / PC the stage supports (64 bits) and the top slices it down.
  localparam int WIDE_W = 64;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [7:0]        writereg;
    logic [7:0]        readreg1;
    logic [7:0]        readreg2;
    logic [WIDE_W-1:0] immediate;
    logic [WIDE_W-1:0] branch_target;
    logic              is_jump;
    logic              is_branch;
    logic              illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and the
// register file/ALU. master = the side driving instructions and out_ready,
// slave = the decode stage itself.
interface decode_stage_if #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [PC_W-1:0]       in_pc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_opcode;
  logic [REG_ADDR_W-1:0] out_writereg;
  logic [REG_ADDR_W-1:0] out_readreg1;
  logic [REG_ADDR_W-1:0] out_readreg2;
  logic [DATA_W-1:0]     out_immediate;
  logic [PC_W-1:0]       out_branch_target;
  logic                  out_is_jump;
  logic                  out_is_branch;
  logic                  out_illegal;
  logic [15:0]           decode_count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_writereg, out_readreg1,
           out_readreg2, out_immediate, out_branch_target, out_is_jump,
           out_is_branch, out_illegal, decode_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_writereg, out_readreg1,
           out_readreg2, out_immediate, out_branch_target, out_is_jump,
           out_is_branch, out_illegal, decode_count
  );

endinterface

// File: rtl/decode_fields.sv
// Purpose: combinational instr/pc -> decoded_t mapping.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when to capture the result.
// Ports: instr (32b word), pc (PC_W) in; dec (decoded_t) out.
// Optional feature: DECODE_ILLEGAL_EN flags opcodes above OP_BEQ as illegal.
module decode_fields
  import decode_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output decoded_t        dec
);

  logic [7:0] opcode;
  logic [7:0] offset;
  logic [7:0] imm8;

  always_comb begin
    opcode = instr[OPCODE_LSB +: FIELD_W];
    offset = instr[RD_LSB +: FIELD_W];
    imm8   = instr[RS_LSB +: FIELD_W];

    dec           = '0;
    dec.opcode    = opcode;
    dec.writereg  = instr[RD_LSB +: FIELD_W];
    dec.readreg1  = instr[RT_LSB +: FIELD_W];
    dec.readreg2  = instr[RS_LSB +: FIELD_W];
    dec.immediate = {{(WIDE_W-FIELD_W){imm8[7]}}, imm8};
    // Word-offset branch: pc + 4 + sext(offset)*4; truncation at the top gives
    // the wrap modulo 2^PC_W.
    dec.branch_target = WIDE_W'(pc) + WIDE_W'(4)
                      + {{(WIDE_W-FIELD_W-2){offset[7]}}, offset, 2'b00};
    // OP_J / OP_BEQ are both inside the legal table, so an illegal opcode
    // can never raise these flags.
    dec.is_jump   = (opcode == OP_J);
    dec.is_branch = (opcode == OP_BEQ);
`ifdef DECODE_ILLEGAL_EN
    dec.illegal   = (opcode > OP_BEQ);
`else
    dec.illegal   = 1'b0;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Purpose: registered instruction-decode stage with a two-entry skid buffer.
// Latency: one cycle from input handshake to out_valid.
// Backpressure: in_ready (registered) drops once the skid entry fills; full rate otherwise.
// Ports: CLK, RESET (synchronous, active low), bus (decode_stage_if.slave).
// Optional feature: DECODE_ILLEGAL_EN enables the illegal-opcode flag.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 32
) (
  input logic           CLK,
  input logic           RESET,
  decode_stage_if.slave bus
);

  decoded_t    in_dec;
  decoded_t    main_q;
  decoded_t    skid_q;
  logic        main_vld;
  logic        skid_vld;
  logic [15:0] count_q;
  logic        accept;
  logic        drain;

  decode_fields #(.PC_W(PC_W)) u_fields (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .dec   (in_dec)
  );

  // in_ready is simply the inverse of the registered skid-valid flag.
  assign accept = bus.in_valid && !skid_vld && !bus.flush;
  assign drain  = main_vld && bus.out_ready;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      count_q  <= '0;
    end else begin
      // A handoff in the flush cycle really happened, so it still counts.
      if (drain) count_q <= count_q + 16'd1;

      if (bus.flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (skid_vld) begin
        // Skid full means in_ready is low: only draining can happen.
        if (drain) begin
          main_q   <= skid_q;
          skid_vld <= 1'b0;
        end
      end else if (accept) begin
        if (!main_vld || drain) begin
          main_q   <= in_dec;
          main_vld <= 1'b1;
        end else begin
          skid_q   <= in_dec;
          skid_vld <= 1'b1;
        end
      end else if (drain) begin
        main_vld <= 1'b0;
      end
    end
  end

  assign bus.in_ready          = !skid_vld;
  assign bus.out_valid         = main_vld;
  assign bus.out_opcode        = main_q.opcode;
  assign bus.out_writereg      = main_q.writereg[REG_ADDR_W-1:0];
  assign bus.out_readreg1      = main_q.readreg1[REG_ADDR_W-1:0];
  assign bus.out_readreg2      = main_q.readreg2[REG_ADDR_W-1:0];
  assign bus.out_immediate     = main_q.immediate[DATA_W-1:0];
  assign bus.out_branch_target = main_q.branch_target[PC_W-1:0];
  assign bus.out_is_jump       = main_q.is_jump;
  assign bus.out_is_branch     = main_q.is_branch;
  assign bus.out_illegal       = main_q.illegal;
  assign bus.decode_count      = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic, checked each
// cycle against a queue-based model of the held instructions.
module tb_decode_stage;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int PC_W       = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W)) bus ();

  decode_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]            op;
    logic [REG_ADDR_W-1:0] wr, r1, r2;
    logic [DATA_W-1:0]     imm;
    logic [PC_W-1:0]       tgt;
    logic                  j, b, ill;
  } exp_t;

  exp_t        held[$];
  int unsigned handoffs = 0;
  logic        exp_in_ready = 1'b1;
  bit          zero_data = 1'b1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    exp_t   e;
    int     imm_s;
    int     off_s;
    longint t;
    e.op  = instr[31:24];
    e.wr  = REG_ADDR_W'(instr >> 16);
    e.r1  = REG_ADDR_W'(instr >> 8);
    e.r2  = REG_ADDR_W'(instr);
    imm_s = int'(instr[7:0]);
    if (imm_s > 127) imm_s -= 256;
    e.imm = DATA_W'(imm_s);
    off_s = int'(instr[23:16]);
    if (off_s > 127) off_s -= 256;
    t     = longint'(pc) + 4 + 4 * longint'(off_s);
    e.tgt = PC_W'(t);
    e.j   = (e.op == 8'h06);
    e.b   = (e.op == 8'h07);
`ifdef DECODE_ILLEGAL_EN
    e.ill = (e.op > 8'h07);
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  // One clock: update the model from the inputs at the edge, then compare at
  // the falling edge.
  task automatic cycle();
    bit   acc;
    exp_t f;
    @(posedge clk);
    if (!rst_n) begin
      held.delete();
      handoffs     = 0;
      exp_in_ready = 1'b1;
      zero_data    = 1'b1;
    end else begin
      acc = bus.in_valid && exp_in_ready && !bus.flush;
      if (held.size() > 0 && bus.out_ready) begin
        handoffs++;
        void'(held.pop_front());
      end
      if (bus.flush) begin
        held.delete();
      end else if (acc) begin
        held.push_back(predict(bus.in_instr, bus.in_pc));
        zero_data = 1'b0;
      end
      exp_in_ready = (held.size() < 2);
    end
    @(negedge clk);
    chk("out_valid", bus.out_valid, held.size() > 0);
    chk("in_ready", bus.in_ready, exp_in_ready);
    chk("decode_count", bus.decode_count, 16'(handoffs));
    if (held.size() > 0) begin
      f = held[0];
      chk("opcode", bus.out_opcode, f.op);
      chk("writereg", bus.out_writereg, f.wr);
      chk("readreg1", bus.out_readreg1, f.r1);
      chk("readreg2", bus.out_readreg2, f.r2);
      chk("immediate", bus.out_immediate, f.imm);
      chk("branch_target", bus.out_branch_target, f.tgt);
      chk("is_jump", bus.out_is_jump, f.j);
      chk("is_branch", bus.out_is_branch, f.b);
      chk("illegal", bus.out_illegal, f.ill);
    end else if (zero_data) begin
      chk("rst_opcode", bus.out_opcode, 0);
      chk("rst_regs", {bus.out_writereg, bus.out_readreg1, bus.out_readreg2}, 0);
      chk("rst_immediate", bus.out_immediate, 0);
      chk("rst_target", bus.out_branch_target, 0);
      chk("rst_flags", {bus.out_is_jump, bus.out_is_branch, bus.out_illegal}, 0);
    end
  endtask

  task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      done = exp_in_ready && !bus.flush;
      cycle();
    end
    chk("send_accepted", done, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;

    // Single ADD
    bus.out_ready = 1'b1;
    send(32'h02050301, 32'h100);
    chk("add_opcode", bus.out_opcode, 8'h02);
    chk("add_writereg", bus.out_writereg, 3'd5);
    chk("add_readreg1", bus.out_readreg1, 3'd3);
    chk("add_readreg2", bus.out_readreg2, 3'd1);
    cycle();
    chk("add_count", bus.decode_count, 16'd1);

    // Branch targets, backwards and forwards
    send(32'h07FE0201, 32'h100);
    chk("beq_back_target", bus.out_branch_target, 32'hFC);
    chk("beq_is_branch", bus.out_is_branch, 1'b1);
    send(32'h077F0201, 32'h100);
    chk("beq_fwd_target", bus.out_branch_target, 32'h300);

    // Negative immediate sign extension
    send(32'h00000080, 32'h200);
    chk("loadi_imm", bus.out_immediate, 16'hFF80);
    cycle();

    // Back-pressure: two accepted, third waits, then all drain in order
    bus.out_ready = 1'b0;
    send(32'h03010203, 32'h400);
    send(32'h04020304, 32'h404);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h05030405;
    bus.in_pc    = 32'h408;
    cycle();
    chk("bp_held_two", bus.out_opcode, 8'h03);
    bus.out_ready = 1'b1;
    send(32'h05030405, 32'h408);
    send(32'h06FF0000, 32'h40C);
    repeat (3) cycle();
    chk("bp_count", bus.decode_count, 16'd8);

    // Flush with both entries full and a new instruction presented
    bus.out_ready = 1'b0;
    send(32'h01010101, 32'h500);
    send(32'h02020202, 32'h504);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h03030303;
    bus.in_pc    = 32'h508;
    bus.flush    = 1'b1;
    cycle();
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    chk("flush_count", bus.decode_count, 16'd8);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    chk("flush_not_accepted", bus.out_valid, 1'b0);

    // Opcode outside the table
    bus.out_ready = 1'b1;
    send(32'h09010203, 32'h600);
`ifdef DECODE_ILLEGAL_EN
    chk("illegal_flag", bus.out_illegal, 1'b1);
`else
    chk("illegal_flag", bus.out_illegal, 1'b0);
`endif
    chk("illegal_no_jump", bus.out_is_jump, 1'b0);
    chk("illegal_no_branch", bus.out_is_branch, 1'b0);
    cycle();

    // Random traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = {8'($urandom_range(0, 11)), 24'($urandom)};
      bus.in_pc     = PC_W'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    bus.flush = 1'b0;

    // Reset while holding two entries
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    chk("midreset_out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;

    // 65536 back-to-back handoffs wrap the counter to zero
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 70000 && handoffs < 65536; i++) begin
      bus.in_instr = $urandom;
      bus.in_pc    = PC_W'($urandom);
      cycle();
    end
    chk("count_wrap", bus.decode_count, 16'h0000);
    bus.in_valid = 1'b0;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
